// File: rtl/alu_share_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter_pkg
// Shared constants and small helpers for the ALU sharing arbiter.
// No ports.
// -----------------------------------------------------------------------------
package alu_share_arbiter_pkg;

  import operationList::*;

  // Number of requesters sharing the ALU.
  localparam int unsigned N_REQ = 2;

  // True when the opcode is one the ALU actually implements.
  function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
    logic legal;
    case (op)
      ADD, SUB, AND, OR: legal = 1'b1;
      default:           legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Requester index to one-hot response-valid vector.
  function automatic logic [N_REQ-1:0] id_to_onehot(input logic id);
    logic [N_REQ-1:0] oh;
    if (id) begin
      oh = 2'b10;
    end else begin
      oh = 2'b01;
    end
    return oh;
  endfunction

endpackage

// File: rtl/operationList.sv
// -----------------------------------------------------------------------------
// operationList
// Opcode encodings shared by the ALU and every block that issues ALU work.
// No ports; packages only.
// -----------------------------------------------------------------------------
package operationList;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] ADD = 4'h0;
  localparam logic [OPC_W-1:0] SUB = 4'h1;
  localparam logic [OPC_W-1:0] AND = 4'h2;
  localparam logic [OPC_W-1:0] OR  = 4'h3;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter_if
// Bundles the two request channels, the shared response channel and the
// ALU-side bus of the ALU sharing arbiter.
//   slave  : view of the arbiter (takes requests, drives the ALU)
//   master : view of the surroundings (requesters plus the ALU instance)
// Signals:
//   req_valid/req_ready [1:0]   per-requester request handshake
//   reqN_op/reqN_a/reqN_b       request payload of requester N
//   resp_valid/resp_ready [1:0] one-hot response handshake
//   resp_data/resp_zero/resp_err shared response payload
//   alu_available/alu_operation/alu_inp1/alu_inp2  registered ALU inputs
//   alu_outp/alu_zero           combinational ALU result
// -----------------------------------------------------------------------------
interface alu_share_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4
);

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [OP_W-1:0]   req0_op;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req0_b;
  logic [DATA_W-1:0] req1_b;

  logic [1:0]        resp_valid;
  logic [1:0]        resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_zero;
  logic              resp_err;

  logic              alu_available;
  logic [OP_W-1:0]   alu_operation;
  logic [DATA_W-1:0] alu_inp1;
  logic [DATA_W-1:0] alu_inp2;
  logic [DATA_W-1:0] alu_outp;
  logic              alu_zero;

  modport slave (
    input  req_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b,
    input  resp_ready, alu_outp, alu_zero,
    output req_ready, resp_valid, resp_data, resp_zero, resp_err,
    output alu_available, alu_operation, alu_inp1, alu_inp2
  );

  modport master (
    output req_valid, req0_op, req1_op, req0_a, req1_a, req0_b, req1_b,
    output resp_ready, alu_outp, alu_zero,
    input  req_ready, resp_valid, resp_data, resp_zero, resp_err,
    input  alu_available, alu_operation, alu_inp1, alu_inp2
  );

endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter_rr_arb2
// Two-way round-robin grant. A lone request always wins; on contention the
// requester named by i_prio wins.
//   i_req   [1:0]  request vector
//   i_prio         favoured requester on contention
//   o_grant [1:0]  one-hot grant (00 when nobody requests)
// -----------------------------------------------------------------------------
module alu_share_arbiter_rr_arb2 (
  input  logic [1:0] i_req,
  input  logic       i_prio,
  output logic [1:0] o_grant
);

  // Grant decode from the request vector and the priority pointer.
  always_comb begin
    o_grant = 2'b00;
    case (i_req)
      2'b01: o_grant = 2'b01;
      2'b10: o_grant = 2'b10;
      2'b11: begin
        if (i_prio) begin
          o_grant = 2'b10;
        end else begin
          o_grant = 2'b01;
        end
      end
      default: o_grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU between two requesters. Arbitrates
// round-robin, registers the winning operation onto the ALU bus, captures
// the result one cycle later and returns it on a one-hot valid/ready
// response channel. Only one transaction is in flight at a time.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    alu_share_arbiter_if.slave (requests, response, ALU bus)
// -----------------------------------------------------------------------------
module alu_share_arbiter
  import operationList::*;
  import alu_share_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4
) (
  input logic                clk,
  input logic                rst_n,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_prio;
  logic              r_winner;
  logic [1:0]        r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_zero;
  logic              r_resp_err;
  logic              r_alu_available;
  logic [OP_W-1:0]   r_alu_operation;
  logic [DATA_W-1:0] r_alu_inp1;
  logic [DATA_W-1:0] r_alu_inp2;

  logic [1:0]        w_grant;
  logic [1:0]        w_req_ready;
  logic              w_accept;
  logic              w_win_id;
  logic              w_resp_hs;
  logic              w_op_legal;
  logic [OP_W-1:0]   w_sel_op;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;

  alu_share_arbiter_rr_arb2 u_arb (
    .i_req   (bus.req_valid),
    .i_prio  (r_prio),
    .o_grant (w_grant)
  );

  // Ready is offered only in IDLE and only to the arbitration winner.
  always_comb begin
    w_req_ready = 2'b00;
    if (r_state == IDLE) begin
      w_req_ready = w_grant;
    end else begin
      w_req_ready = 2'b00;
    end
  end

  assign w_accept   = |(bus.req_valid & w_req_ready);
  assign w_win_id   = w_grant[1];
  assign w_resp_hs  = (r_state == RESP) && bus.resp_ready[r_winner];
  assign w_op_legal = is_legal_op(r_alu_operation);

  // Payload of the requester that wins this cycle.
  always_comb begin
    w_sel_op = bus.req0_op;
    w_sel_a  = bus.req0_a;
    w_sel_b  = bus.req0_b;
    if (w_win_id) begin
      w_sel_op = bus.req1_op;
      w_sel_a  = bus.req1_a;
      w_sel_b  = bus.req1_b;
    end else begin
      w_sel_op = bus.req0_op;
      w_sel_a  = bus.req0_a;
      w_sel_b  = bus.req0_b;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state decode; ISSUE always lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: w_state_nxt = RESP;
      RESP: begin
        if (w_resp_hs) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath: ALU operand registers, priority pointer and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio          <= 1'b0;
      r_winner        <= 1'b0;
      r_resp_valid    <= 2'b00;
      r_resp_data     <= {DATA_W{1'b0}};
      r_resp_zero     <= 1'b0;
      r_resp_err      <= 1'b0;
      r_alu_available <= 1'b0;
      r_alu_operation <= {OP_W{1'b0}};
      r_alu_inp1      <= {DATA_W{1'b0}};
      r_alu_inp2      <= {DATA_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_alu_operation <= w_sel_op;
            r_alu_inp1      <= w_sel_a;
            r_alu_inp2      <= w_sel_b;
            r_alu_available <= 1'b1;
            r_winner        <= w_win_id;
            // Loser of this round is favoured next time.
            r_prio          <= ~w_win_id;
          end
        end
        ISSUE: begin
          r_alu_available <= 1'b0;
          r_resp_valid    <= id_to_onehot(r_winner);
          r_resp_err      <= ~w_op_legal;
          // An unknown opcode must not leak whatever the ALU produced.
          if (w_op_legal) begin
            r_resp_data <= bus.alu_outp;
            r_resp_zero <= bus.alu_zero;
          end else begin
            r_resp_data <= {DATA_W{1'b0}};
            r_resp_zero <= 1'b0;
          end
        end
        RESP: begin
          if (w_resp_hs) begin
            r_resp_valid <= 2'b00;
          end
        end
        default: begin
          r_resp_valid    <= 2'b00;
          r_alu_available <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready     = w_req_ready;
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_data     = r_resp_data;
  assign bus.resp_zero     = r_resp_zero;
  assign bus.resp_err      = r_resp_err;
  assign bus.alu_available = r_alu_available;
  assign bus.alu_operation = r_alu_operation;
  assign bus.alu_inp1      = r_alu_inp1;
  assign bus.alu_inp2      = r_alu_inp2;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
// Directed bench for alu_share_arbiter with a behavioural ALU beside it.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

  import operationList::*;

  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [3:0]    p_op [2];
  logic [DW-1:0] p_a  [2];
  logic [DW-1:0] p_b  [2];

  logic [DW-1:0] alu_res;
  logic          alu_z;

  alu_share_arbiter_if #(.DATA_W(DW), .OP_W(4)) bus ();

  alu_share_arbiter #(.DATA_W(DW), .OP_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; unknown opcodes give junk so the error path is visible.
  always_comb begin
    alu_z = 1'b1;
    case (bus.alu_operation)
      ADD: begin alu_res = bus.alu_inp1 + bus.alu_inp2; alu_z = (alu_res == 32'd0); end
      SUB: begin alu_res = bus.alu_inp1 - bus.alu_inp2; alu_z = (alu_res == 32'd0); end
      AND: begin alu_res = bus.alu_inp1 & bus.alu_inp2; alu_z = (alu_res == 32'd0); end
      OR:  begin alu_res = bus.alu_inp1 | bus.alu_inp2; alu_z = (alu_res == 32'd0); end
      default: alu_res = 32'hDEAD_BEEF;
    endcase
  end

  assign bus.alu_outp = alu_res;
  assign bus.alu_zero = alu_z;

  assign bus.req0_op = p_op[0];
  assign bus.req1_op = p_op[1];
  assign bus.req0_a  = p_a[0];
  assign bus.req1_a  = p_a[1];
  assign bus.req0_b  = p_b[0];
  assign bus.req1_b  = p_b[1];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int id, input logic [3:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
    p_op[id] = op;
    p_a[id]  = a;
    p_b[id]  = b;
  endtask

  // Offer vld, expect grant gnt, then follow the transaction into RESP.
  task automatic issue_txn(input string tag, input logic [1:0] vld, input logic [1:0] gnt,
                           input bit hold, input logic [DW-1:0] exp_d,
                           input logic exp_z, input logic exp_e);
    int w;
    w = gnt[1] ? 1 : 0;
    bus.req_valid = vld;
    #1;
    check_val({tag, " req_ready idle"}, 64'(bus.req_ready), 64'(gnt));
    @(posedge clk); #1;
    if (!hold) bus.req_valid = 2'b00;
    check_val({tag, " alu_available issue"}, 64'(bus.alu_available), 64'd1);
    check_val({tag, " alu_operation"}, 64'(bus.alu_operation), 64'(p_op[w]));
    check_val({tag, " alu_inp1"}, 64'(bus.alu_inp1), 64'(p_a[w]));
    check_val({tag, " alu_inp2"}, 64'(bus.alu_inp2), 64'(p_b[w]));
    check_val({tag, " req_ready issue"}, 64'(bus.req_ready), 64'd0);
    check_val({tag, " resp_valid issue"}, 64'(bus.resp_valid), 64'd0);
    @(posedge clk); #1;
    check_val({tag, " resp_valid"}, 64'(bus.resp_valid), 64'(gnt));
    check_val({tag, " resp_data"}, 64'(bus.resp_data), 64'(exp_d));
    check_val({tag, " resp_zero"}, 64'(bus.resp_zero), 64'(exp_z));
    check_val({tag, " resp_err"}, 64'(bus.resp_err), 64'(exp_e));
    check_val({tag, " alu_available resp"}, 64'(bus.alu_available), 64'd0);
    check_val({tag, " req_ready resp"}, 64'(bus.req_ready), 64'd0);
  endtask

  task automatic resp_txn(input string tag, input logic [1:0] rdy);
    bus.resp_ready = rdy;
    @(posedge clk); #1;
    bus.resp_ready = 2'b00;
    check_val({tag, " resp_valid after hs"}, 64'(bus.resp_valid), 64'd0);
  endtask

  // Hard stop if something wedges the sequence below.
  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 2'b00;
    bus.resp_ready = 2'b00;
    set_req(0, ADD, 32'd0, 32'd0);
    set_req(1, ADD, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_val("rst resp_valid", 64'(bus.resp_valid), 64'd0);
    check_val("rst resp_data", 64'(bus.resp_data), 64'd0);
    check_val("rst resp_zero", 64'(bus.resp_zero), 64'd0);
    check_val("rst resp_err", 64'(bus.resp_err), 64'd0);
    check_val("rst alu_available", 64'(bus.alu_available), 64'd0);
    check_val("rst alu_operation", 64'(bus.alu_operation), 64'd0);
    check_val("rst alu_inp1", 64'(bus.alu_inp1), 64'd0);
    check_val("rst alu_inp2", 64'(bus.alu_inp2), 64'd0);
    check_val("rst req_ready", 64'(bus.req_ready), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single request: 5 + 7 = 12.
    set_req(0, ADD, 32'd5, 32'd7);
    issue_txn("add", 2'b01, 2'b01, 1'b0, 32'd12, 1'b0, 1'b0);
    resp_txn("add", 2'b01);

    // SUB equality from requester 1.
    set_req(1, SUB, 32'h1234, 32'h1234);
    issue_txn("sub_eq", 2'b10, 2'b10, 1'b0, 32'd0, 1'b1, 1'b0);
    resp_txn("sub_eq", 2'b10);

    // Contention, both held valid: grants alternate 0,1,0,1.
    set_req(0, ADD, 32'd1, 32'd2);
    set_req(1, OR, 32'h0000_00F0, 32'h0000_000F);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) begin
        issue_txn("rr0", 2'b11, 2'b01, 1'b1, 32'd3, 1'b0, 1'b0);
      end else begin
        issue_txn("rr1", 2'b11, 2'b10, 1'b1, 32'h0000_00FF, 1'b0, 1'b0);
      end
      resp_txn("rr", 2'b11);
    end
    bus.req_valid = 2'b00;

    // SUB wraps: 3 - 5.
    set_req(0, SUB, 32'd3, 32'd5);
    issue_txn("sub_neg", 2'b01, 2'b01, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);
    resp_txn("sub_neg", 2'b01);

    // Response backpressure on requester 1 with requester 0 waiting.
    set_req(1, AND, 32'hFF00_FF00, 32'h0FF0_0FF0);
    issue_txn("bp", 2'b10, 2'b10, 1'b0, 32'h0F00_0F00, 1'b0, 1'b0);
    set_req(0, ADD, 32'd9, 32'd9);
    bus.req_valid = 2'b01;
    for (int i = 0; i < 10; i++) begin
      bus.resp_ready = (i < 5) ? 2'b00 : 2'b01;
      @(posedge clk); #1;
      check_val("bp hold resp_valid", 64'(bus.resp_valid), 64'h2);
      check_val("bp hold resp_data", 64'(bus.resp_data), 64'h0F00_0F00);
      check_val("bp hold req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.resp_ready = 2'b10;
    @(posedge clk); #1;
    bus.resp_ready = 2'b00;
    check_val("bp release resp_valid", 64'(bus.resp_valid), 64'd0);
    check_val("bp release req_ready", 64'(bus.req_ready), 64'h1);
    bus.req_valid = 2'b00;
    @(posedge clk); #1;
    check_val("bp dropped alu_available", 64'(bus.alu_available), 64'd0);

    // Illegal opcode, then a legal one with wraparound.
    set_req(0, 4'hF, 32'd1, 32'd1);
    issue_txn("illegal", 2'b01, 2'b01, 1'b0, 32'd0, 1'b0, 1'b1);
    resp_txn("illegal", 2'b01);
    set_req(1, ADD, 32'hFFFF_FFFF, 32'd2);
    issue_txn("after_ill", 2'b10, 2'b10, 1'b0, 32'd1, 1'b0, 1'b0);
    resp_txn("after_ill", 2'b10);

    // Reset while in ISSUE discards the transaction.
    set_req(1, ADD, 32'd10, 32'd20);
    bus.req_valid = 2'b10;
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    check_val("rst_issue pre alu_available", 64'(bus.alu_available), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_val("rst_issue resp_valid", 64'(bus.resp_valid), 64'd0);
    check_val("rst_issue alu_available", 64'(bus.alu_available), 64'd0);
    check_val("rst_issue alu_operation", 64'(bus.alu_operation), 64'd0);
    @(posedge clk); #1;
    check_val("rst_issue no late resp", 64'(bus.resp_valid), 64'd0);

    // Reset while in RESP, after requester 0 won (pointer now favours 1).
    set_req(0, ADD, 32'd4, 32'd4);
    issue_txn("pre_rst", 2'b01, 2'b01, 1'b0, 32'd8, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_val("rst_resp resp_valid", 64'(bus.resp_valid), 64'd0);
    check_val("rst_resp resp_data", 64'(bus.resp_data), 64'd0);
    check_val("rst_resp alu_available", 64'(bus.alu_available), 64'd0);

    // Pointer is back at requester 0 after reset.
    set_req(0, SUB, 32'd7, 32'd7);
    set_req(1, OR, 32'd1, 32'd2);
    issue_txn("post_rst", 2'b11, 2'b01, 1'b0, 32'd0, 1'b1, 1'b0);
    resp_txn("post_rst", 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
